// File: rtl/branch_pkg.sv
// Shared encodings for the branch predict unit: RV32I branch funct3 codes,
// 2-bit BHT counter states, PC-select encodings, saturating counter step.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_e;

    typedef enum logic [1:0] {
        PCSEL_SEQ   = 2'b00,
        PCSEL_TGT   = 2'b01,
        PCSEL_RECOV = 2'b10
    } pc_sel_e;

    function automatic bht_cnt_e cnt_next(input bht_cnt_e cur, input logic taken);
        bht_cnt_e nxt;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_hist_table.sv
// Direct-mapped table of 2-bit saturating counters, async reset to weakly-not-taken.
// Latency: read is combinational; update lands on the next rising edge.
// Backpressure: none; an update is accepted every cycle it is enabled.
module branch_hist_table
    import branch_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_taken,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    localparam int DEPTH = 2 ** IDX_W;

    bht_cnt_e r_cnt [DEPTH];
    bht_cnt_e w_rd_cnt;

    // Read sees the pre-update value when the same entry is trained this cycle.
    assign w_rd_cnt   = r_cnt[i_rd_idx];
    assign o_rd_taken = (w_rd_cnt == WT) || (w_rd_cnt == ST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= WNT;
            end
        end else if (i_upd_en) begin
            r_cnt[i_upd_idx] <= cnt_next(r_cnt[i_upd_idx], i_upd_taken);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution with mispredict/redirect select, plus IF-stage BHT prediction.
// Latency: EX outputs and prediction are combinational; BHT and perf counters update on posedge.
// Backpressure: none. Optional saturating perf counters enabled by BRU_PERF_CNT_EN.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic [2:0]       ex_funct3,
    input  logic             ex_zero,
    input  logic             ex_sign,
    input  logic             ex_ltu,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    output logic             pc_src,
    output logic             mispredict,
    output logic [1:0]       pc_sel,
    output logic             illegal_br,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispred
);

    logic w_cond;
    logic w_illegal_f3;
    logic w_ctrl;
    logic w_bht_upd;
    logic w_unused_pc;

    always_comb begin
        w_cond       = 1'b0;
        w_illegal_f3 = 1'b0;
        case (ex_funct3)
            F3_BEQ:  w_cond = ex_zero;
            F3_BNE:  w_cond = ~ex_zero;
            F3_BLT:  w_cond = ex_sign;
            F3_BGE:  w_cond = ~ex_sign;
            F3_BLTU: w_cond = ex_ltu;
            F3_BGEU: w_cond = ~ex_ltu;
            default: w_illegal_f3 = 1'b1;
        endcase
    end

    assign w_ctrl     = ex_valid & (ex_branch | ex_jump);
    assign pc_src     = ex_valid & (ex_jump | (ex_branch & w_cond));
    assign mispredict = w_ctrl & (pc_src != ex_pred_taken);
    assign illegal_br = ex_valid & ex_branch & w_illegal_f3;

    always_comb begin
        pc_sel = PCSEL_SEQ;
        if (mispredict) begin
            pc_sel = pc_src ? PCSEL_TGT : PCSEL_RECOV;
        end
    end

    // Jumps (including branch+jump) and illegal encodings leave the table alone.
    assign w_bht_upd = ex_valid & ex_branch & ~ex_jump & ~w_illegal_f3;

    branch_hist_table #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_idx    (if_pc[BHT_IDX_W+1:2]),
        .o_rd_taken  (if_pred_taken),
        .i_upd_en    (w_bht_upd),
        .i_upd_idx   (ex_pc[BHT_IDX_W+1:2]),
        .i_upd_taken (w_cond)
    );

    assign w_unused_pc = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0],
                           ex_pc[XLEN-1:BHT_IDX_W+2], ex_pc[1:0]};

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_br;
    logic [CNT_W-1:0] r_perf_mp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_br <= '0;
            r_perf_mp <= '0;
        end else begin
            if (w_ctrl && (r_perf_br != '1)) begin
                r_perf_br <= r_perf_br + CNT_W'(1);
            end
            if (mispredict && (r_perf_mp != '1)) begin
                r_perf_mp <= r_perf_mp + CNT_W'(1);
            end
        end
    end

    assign perf_branches = r_perf_br;
    assign perf_mispred  = r_perf_mp;
`else
    assign perf_branches = '0;
    assign perf_mispred  = '0;
`endif

endmodule
